// File: rtl/xnor_match_pipe.sv
// xnor_match_pipe: two-stage masked XNOR compare with popcount score, threshold
// match and a saturating running total of the scores of delivered results.
module xnor_match_pipe #(
   parameter int WIDTH  = 8,
   parameter int THRESH = WIDTH,
   parameter int ACC_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic [WIDTH-1:0]           mask,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           y,
   output logic [$clog2(WIDTH+1)-1:0] score,
   output logic                       match,
   output logic                       all_eq,
   input  logic                       clear,
   output logic [ACC_W-1:0]           acc,
   output logic                       acc_sat
);

   localparam int SCORE_W = $clog2(WIDTH+1);
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   function automatic logic [SCORE_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [SCORE_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) n = n + SCORE_W'(v[i]);
      return n;
   endfunction

   // Returns {saturated, next accumulator}; reaching the ceiling exactly counts as saturation.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] cur,
                                              input logic [SCORE_W-1:0] s);
      logic [ACC_W:0] sum;
      sum = {1'b0, cur} + (ACC_W+1)'(s);
      if (sum >= {1'b0, ACC_MAX}) return {1'b1, ACC_MAX};
      return {1'b0, sum[ACC_W-1:0]};
   endfunction

   logic                 vld_p1;
   logic [WIDTH-1:0]     y_p1;
   logic [WIDTH-1:0]     mask_p1;
   logic                 vld_p2;
   logic [WIDTH-1:0]     y_p2;
   logic [SCORE_W-1:0]   score_p2;
   logic                 match_p2;
   logic                 all_eq_p2;
   logic                 en1;
   logic                 en2;
   logic [SCORE_W-1:0]   score_c;
   logic                 match_c;
   logic [ACC_W:0]       acc_nxt;

   assign en2      = !vld_p2 || out_ready;
   assign en1      = !vld_p1 || en2;
   assign in_ready = en1;

   assign score_c = popcount(y_p1);
   assign match_c = (int'(score_c) >= THRESH);
   assign acc_nxt = sat_add(acc, score);

   // Stage 1: masked XNOR of the operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         y_p1    <= '0;
         mask_p1 <= '0;
      end else if (en1) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            y_p1    <= ~(a ^ b) & mask;
            mask_p1 <= mask;
         end
      end
   end

   // Stage 2: score, threshold and all-equal flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2    <= 1'b0;
         y_p2      <= '0;
         score_p2  <= '0;
         match_p2  <= 1'b0;
         all_eq_p2 <= 1'b0;
      end else if (en2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            y_p2      <= y_p1;
            score_p2  <= score_c;
            match_p2  <= match_c;
            all_eq_p2 <= (y_p1 == mask_p1);
         end
      end
   end

   // Accumulator: clear wins over a coincident output handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         acc_sat <= 1'b0;
      end else if (clear) begin
         acc     <= '0;
         acc_sat <= 1'b0;
      end else if (out_valid && out_ready) begin
         acc <= acc_nxt[ACC_W-1:0];
         if (acc_nxt[ACC_W]) acc_sat <= 1'b1;
      end
   end

   assign out_valid = vld_p2;
   assign y         = y_p2;
   assign score     = score_p2;
   assign match     = match_p2;
   assign all_eq    = all_eq_p2;

endmodule
